// File: rtl/wave_pkg.sv
// Shared types for the wave string engine: word-type codes, FSM states and the
// triangular ramp helper used by the colour ramps.
package wave_pkg;

  typedef enum logic [1:0] {
    WORD_START = 2'd0,
    WORD_LED   = 2'd1,
    WORD_END   = 2'd2
  } word_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STROBE,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_e;

  localparam int RAMP_W = 16;

  // Segment multiplier for a wrapped phase: ascending, descending, then zero.
  function automatic logic [RAMP_W-1:0] ramp_mult(input logic [RAMP_W-1:0] pos,
                                                  input logic [RAMP_W-1:0] seg_len);
    if (pos < seg_len) begin
      return pos;
    end else if (pos < (seg_len << 1)) begin
      return (seg_len << 1) - RAMP_W'(1) - pos;
    end else begin
      return '0;
    end
  endfunction

endpackage

// File: rtl/wave_string_gen_if.sv
// LED serializer word bus: the generator (master) presents a typed RGB word and
// a one-cycle start strobe; the serializer (slave) answers with busy.
interface wave_string_gen_if #(
  parameter int CW = 8
) ();
  logic          led_start;
  logic [1:0]    led_type;
  logic [CW-1:0] blue_out;
  logic [CW-1:0] green_out;
  logic [CW-1:0] red_out;
  logic          led_busy;

  modport master (output led_start, led_type, blue_out, green_out, red_out,
                  input  led_busy);
  modport slave  (input  led_start, led_type, blue_out, green_out, red_out,
                  output led_busy);
endinterface

// File: rtl/wave_color_ramp.sv
// Combinational colour ramp: (frame phase, channel offset) -> saturated CW-bit level.
module wave_color_ramp
  import wave_pkg::*;
#(
  parameter int CW         = 8,
  parameter int SEG_LEN    = 30,
  parameter int COLOR_STEP = 6,
  parameter int PH_W       = 7
) (
  input  logic [PH_W-1:0] phase,
  input  logic [1:0]      offset,
  output logic [CW-1:0]   level
);

  localparam int PW = CW + 8;
  localparam logic [PH_W:0] PH_MAX = (PH_W+1)'(3 * SEG_LEN);
  localparam logic [PW-1:0] SAT    = PW'((1 << CW) - 1);

  logic [PH_W:0]       off, sum, wrapped;
  logic [RAMP_W-1:0]   mult;
  logic [PW-1:0]       prod;

  // NOTE: every variable written in always_comb is defaulted or fully
  // assigned on every path, otherwise synthesis infers a latch.
  always_comb begin
    case (offset)
      2'd0:    off = '0;
      2'd1:    off = (PH_W+1)'(SEG_LEN);
      default: off = (PH_W+1)'(2 * SEG_LEN);
    endcase
    sum     = {1'b0, phase} + off;
    wrapped = (sum >= PH_MAX) ? sum - PH_MAX : sum;
    mult    = ramp_mult(RAMP_W'(wrapped), RAMP_W'(SEG_LEN));
    prod    = PW'(mult) * PW'(COLOR_STEP);
    level   = (prod > SAT) ? '1 : prod[CW-1:0];
  end

endmodule

// File: rtl/wave_string_gen.sv
// Wand column generator: START, STRING_SIZE LED words, END per frame, with a
// triangle-scrolling white band. Optional WAVE_BRIGHTNESS_EN adds a brightness shift.
module wave_string_gen
  import wave_pkg::*;
#(
  parameter int STRING_SIZE    = 47,
  parameter int NUMBER_STRINGS = 47,
  parameter int CW             = 8,
  parameter int WAVE_BASE      = 3,
  parameter int WAVE_AMPL      = 40,
  parameter int BAND_W         = 1,
  parameter int WHITE_LEVEL    = 150,
  parameter int SEG_LEN        = 30,
  parameter int COLOR_STEP     = 6
) (
  input  logic dostring_clk,
  input  logic dostring_reset,
  input  logic enable,
`ifdef WAVE_BRIGHTNESS_EN
  input  logic [2:0] brightness,
`endif
  wave_string_gen_if.master led,
  output logic frame_done,
  output logic sweep_done
);

  localparam int IDX_W = $clog2(STRING_SIZE + 2);
  localparam int COL_W = $clog2(NUMBER_STRINGS + 1);
  localparam int PH_W  = $clog2(3 * SEG_LEN + 1);
  localparam int TRI_W = $clog2(WAVE_AMPL + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STRING_SIZE + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUMBER_STRINGS - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(3 * SEG_LEN - 1);
  localparam logic [TRI_W-1:0] TRI_TOP  = TRI_W'(WAVE_AMPL);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [TRI_W-1:0] tri_q, tri_d;
  logic             dir_up_q, dir_up_d;
  logic [1:0]       to_q, to_d;
  logic             start_q, start_d;
  word_e            type_q, type_d;
  logic [CW-1:0]    red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic             frame_done_q, frame_done_d, sweep_done_q, sweep_done_d;
  logic [2:0]       shift;

`ifdef WAVE_BRIGHTNESS_EN
  logic [2:0] bright_q, bright_d;
  assign shift = bright_q;
`else
  assign shift = 3'd0;
`endif

  logic [CW-1:0] lvl0, lvl1, lvl2;
  wave_color_ramp #(.CW(CW), .SEG_LEN(SEG_LEN), .COLOR_STEP(COLOR_STEP), .PH_W(PH_W))
    u_ramp0 (.phase(ph_q), .offset(2'd0), .level(lvl0));
  wave_color_ramp #(.CW(CW), .SEG_LEN(SEG_LEN), .COLOR_STEP(COLOR_STEP), .PH_W(PH_W))
    u_ramp1 (.phase(ph_q), .offset(2'd1), .level(lvl1));
  wave_color_ramp #(.CW(CW), .SEG_LEN(SEG_LEN), .COLOR_STEP(COLOR_STEP), .PH_W(PH_W))
    u_ramp2 (.phase(ph_q), .offset(2'd2), .level(lvl2));

  // Region decode for the pixel addressed by the current word index.
  logic [IDX_W-1:0] pix, band_lo, band_hi;
  logic [CW-1:0]    base_r, base_g, base_b, pix_r, pix_g, pix_b;

  always_comb begin
    pix     = idx_q - IDX_W'(1);
    band_lo = IDX_W'(WAVE_BASE) + IDX_W'(tri_q);
    band_hi = band_lo + IDX_W'(BAND_W);
    if (pix < band_lo) begin
      {base_r, base_g, base_b} = {lvl2, lvl1, lvl0};
    end else if (pix < band_hi) begin
      {base_r, base_g, base_b} = {3{CW'(WHITE_LEVEL)}};
    end else begin
      {base_r, base_g, base_b} = {lvl1, lvl0, lvl2};
    end
    pix_r = base_r >> shift;
    pix_g = base_g >> shift;
    pix_b = base_b >> shift;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    col_d        = col_q;
    ph_d         = ph_q;
    tri_d        = tri_q;
    dir_up_d     = dir_up_q;
    to_d         = to_q;
    start_d      = 1'b0;
    type_d       = type_q;
    red_d        = red_q;
    green_d      = green_q;
    blue_d       = blue_q;
    frame_done_d = 1'b0;
    sweep_done_d = 1'b0;
`ifdef WAVE_BRIGHTNESS_EN
    bright_d     = bright_q;
`endif

    case (state_q)
      ST_IDLE: if (enable) state_d = ST_LOAD;

      ST_LOAD: begin
        if (idx_q == '0) begin
          type_d = WORD_START;
          {red_d, green_d, blue_d} = '0;
`ifdef WAVE_BRIGHTNESS_EN
          bright_d = brightness;
`endif
        end else if (idx_q == LAST_IDX) begin
          type_d = WORD_END;
          {red_d, green_d, blue_d} = '1;
        end else begin
          type_d = WORD_LED;
          {red_d, green_d, blue_d} = {pix_r, pix_g, pix_b};
        end
        state_d = ST_STROBE;
      end

      ST_STROBE: if (!led.led_busy) begin
        start_d = 1'b1;
        to_d    = '0;
        state_d = ST_WAIT_HI;
      end

      // A serializer that never raises busy is let through after four cycles.
      ST_WAIT_HI: begin
        if (led.led_busy || to_q == 2'd3) state_d = ST_WAIT_LO;
        else                              to_d    = to_q + 2'd1;
      end

      ST_WAIT_LO: if (!led.led_busy) begin
        if (idx_q == LAST_IDX) begin
          idx_d        = '0;
          frame_done_d = 1'b1;
          if (col_q == COL_LAST) begin
            col_d        = '0;
            sweep_done_d = 1'b1;
          end else begin
            col_d = col_q + COL_W'(1);
          end
          ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
          if (dir_up_q) begin
            tri_d = tri_q + TRI_W'(1);
            if (tri_q == TRI_TOP - TRI_W'(1)) dir_up_d = 1'b0;
          end else begin
            tri_d = tri_q - TRI_W'(1);
            if (tri_q == TRI_W'(1)) dir_up_d = 1'b1;
          end
          state_d = enable ? ST_LOAD : ST_IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_LOAD;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      col_q        <= '0;
      ph_q         <= '0;
      tri_q        <= '0;
      dir_up_q     <= 1'b1;
      to_q         <= '0;
      start_q      <= 1'b0;
      type_q       <= WORD_START;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      frame_done_q <= 1'b0;
      sweep_done_q <= 1'b0;
`ifdef WAVE_BRIGHTNESS_EN
      bright_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      col_q        <= col_d;
      ph_q         <= ph_d;
      tri_q        <= tri_d;
      dir_up_q     <= dir_up_d;
      to_q         <= to_d;
      start_q      <= start_d;
      type_q       <= type_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      frame_done_q <= frame_done_d;
      sweep_done_q <= sweep_done_d;
`ifdef WAVE_BRIGHTNESS_EN
      bright_q     <= bright_d;
`endif
    end
  end

  assign led.led_start = start_q;
  assign led.led_type  = type_q;
  assign led.red_out   = red_q;
  assign led.green_out = green_q;
  assign led.blue_out  = blue_q;
  assign frame_done    = frame_done_q;
  assign sweep_done    = sweep_done_q;

endmodule

// File: tb/tb_wave_string_gen.sv
// Self-checking bench for wave_string_gen: a frame-level model predicts every
// strobed word; directed phases cover reset, sweep, stall, disable and abort.
module tb_wave_string_gen;

  localparam int SS    = 47;
  localparam int NS    = 47;
  localparam int WORDS = SS + 2;
  localparam int SEG   = 30;
  localparam int STEP  = 6;
  localparam int AMPL  = 40;
  localparam int BASE  = 3;
  localparam int WHITE = 150;

`ifdef WAVE_BRIGHTNESS_EN
  localparam int BR = 2;
  logic [2:0] brightness = 3'd2;
`else
  localparam int BR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic force_busy = 1'b0;
  logic frame_done, sweep_done;
  int   passed = 0, total = 0;

  wave_string_gen_if #(.CW(8)) led_bus ();

  wave_string_gen dut (
    .dostring_clk  (clk),
    .dostring_reset(rst),
    .enable        (enable),
`ifdef WAVE_BRIGHTNESS_EN
    .brightness    (brightness),
`endif
    .led           (led_bus),
    .frame_done    (frame_done),
    .sweep_done    (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [25:0] packed_out();
    return {led_bus.led_type, led_bus.red_out, led_bus.green_out, led_bus.blue_out};
  endfunction

  // Ramp level straight from the segment rules.
  function automatic int lvl(input int phase);
    int seg, i, v;
    seg = phase / SEG;
    i   = phase % SEG;
    v   = 0;
    if (seg == 0)      v = i * STEP;
    else if (seg == 1) v = (SEG - 1 - i) * STEP;
    if (v > 255) v = 255;
    return v;
  endfunction

  function automatic logic [25:0] model_word(input int f, input int n);
    int p, t, w, ph, r, g, b;
    if (n == 0) return 26'd0;
    if (n == WORDS - 1) return {2'd2, 24'hFFFFFF};
    p  = n - 1;
    t  = f % (2 * AMPL);
    w  = BASE + ((t <= AMPL) ? t : 2 * AMPL - t);
    ph = f % (3 * SEG);
    if (p < w) begin
      b = lvl(ph); g = lvl((ph + SEG) % (3 * SEG)); r = lvl((ph + 2 * SEG) % (3 * SEG));
    end else if (p < w + 1) begin
      r = WHITE; g = WHITE; b = WHITE;
    end else begin
      g = lvl(ph); r = lvl((ph + SEG) % (3 * SEG)); b = lvl((ph + 2 * SEG) % (3 * SEG));
    end
    r = r >> BR; g = g >> BR; b = b >> BR;
    return {2'd1, 8'(r), 8'(g), 8'(b)};
  endfunction

  // Serializer: busy for two cycles after each strobe, or held by force_busy.
  int bcnt = 0;
  initial begin
    led_bus.led_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (led_bus.led_start) bcnt = 2;
      else if (bcnt > 0)     bcnt--;
      led_bus.led_busy = force_busy || (bcnt > 0);
    end
  end

  // Compare process: every strobed word against the model, frame bookkeeping.
  int frame_no = 0, word_no = 0, strobes = 0, frames = 0, sweeps = 0, sweep_frame = -1;
  logic prev_start = 1'b0;
  int   band_pos[128];
  logic [25:0] cap[WORDS];
  logic [25:0] act_w;

  initial begin
    foreach (band_pos[k]) band_pos[k] = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        frame_no = 0; word_no = 0; prev_start = 1'b0;
        continue;
      end
      if (led_bus.led_start) begin
        strobes++;
        check("start_width", 32'(prev_start), 0);
        act_w = packed_out();
        if (word_no >= WORDS) begin
          check("word_overrun", word_no, WORDS - 1);
        end else begin
          check($sformatf("word_f%0d_i%0d", frame_no, word_no), 32'(act_w),
                32'(model_word(frame_no, word_no)));
          if (act_w[25:24] == 2'd1 && act_w[23:16] == 8'(WHITE >> BR) &&
              act_w[15:8] == 8'(WHITE >> BR) && act_w[7:0] == 8'(WHITE >> BR))
            band_pos[frame_no % 128] = word_no - 1;
          if (frame_no == 0) cap[word_no] = act_w;
        end
        word_no++;
      end
      prev_start = led_bus.led_start;
      if (frame_done || sweep_done)
        check("sweep_done", 32'(sweep_done), 32'(frame_done && (frame_no % NS == NS - 1)));
      if (frame_done) begin
        check("frame_words", word_no, WORDS);
        frames++;
        if (sweep_done) begin
          sweeps++;
          sweep_frame = frames;
        end
        frame_no++;
        word_no = 0;
      end
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      step();
      n++;
    end
    if (frames < target) check("timeout_frames", frames, target);
  endtask

  initial begin
    int s0, f0, n;
    logic [25:0] snap;
    logic stable;

    repeat (3) step();
    check("reset_word", 32'(packed_out()), 0);
    check("reset_start", 32'(led_bus.led_start), 0);
    check("reset_done", {frame_done, sweep_done}, 0);
    rst = 1'b0;
    step();
    enable = 1'b1;

    // First frame and pinned literal words.
    wait_frames(1, 2000);
    check("first_frame_strobes", strobes, 49);
    check("first_frame_done", frames, 1);
    check("start_word", 32'(cap[0]), 0);
    check("end_word", 32'(cap[48]), {6'd0, 2'd2, 24'hFFFFFF});
    check("white_p3", 32'(cap[4]), {6'd0, 2'd1, 8'(150 >> BR), 8'(150 >> BR), 8'(150 >> BR)});
    check("top_p0", 32'(cap[1]), {6'd0, 2'd1, 8'd0, 8'(174 >> BR), 8'd0});
    check("top_p2", 32'(cap[3]), {6'd0, 2'd1, 8'd0, 8'(174 >> BR), 8'd0});
    check("bottom_p4", 32'(cap[5]), {6'd0, 2'd1, 8'(174 >> BR), 8'd0, 8'd0});

    // Full sweep.
    wait_frames(NS, NS * 400);
    check("sweep_count", sweeps, 1);
    check("sweep_frame", sweep_frame, 47);
    check("band_f0", band_pos[0], 3);
    check("band_f40", band_pos[40], 43);
    check("band_f41", band_pos[41], 42);
    check("band_f46", band_pos[46], 37);

    // Stall in STROBE with busy held high.
    s0 = strobes; n = 0;
    while (strobes == s0 && n < 100) begin step(); n++; end
    n = 0;
    while (led_bus.led_busy && n < 100) begin step(); n++; end
    step();
    force_busy = 1'b1;
    repeat (3) step();
    snap = packed_out();
    s0 = strobes;
    stable = 1'b1;
    repeat (100) begin
      step();
      if (packed_out() !== snap || led_bus.led_start !== 1'b0) stable = 1'b0;
    end
    check("stall_stable", 32'(stable), 1);
    check("stall_no_strobe", strobes, s0);
    force_busy = 1'b0;
    repeat (4) step();
    check("stall_release_strobe", strobes, s0 + 1);

    // Drop enable at LED word 10; the frame must still finish.
    n = 0;
    while (word_no != 11 && n < 600) begin step(); n++; end
    check("reached_led10", word_no, 11);
    enable = 1'b0;
    f0 = frames;
    wait_frames(f0 + 1, 600);
    s0 = strobes;
    repeat (60) step();
    check("idle_no_strobe", strobes, s0);
    check("disable_frames", frames, f0 + 1);

    // Abort a frame with reset, then restart from frame 0.
    enable = 1'b1;
    n = 0;
    while (word_no < 6 && n < 600) begin step(); n++; end
    rst = 1'b1;
    #1;
    check("abort_word", 32'(packed_out()), 0);
    check("abort_start", 32'(led_bus.led_start), 0);
    repeat (2) step();
    f0 = frames;
    rst = 1'b0;
    wait_frames(f0 + 1, 2000);
    check("restart_band", band_pos[0], 3);
    check("restart_frames", frames, f0 + 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
